// File: rtl/reg_bank_responder.sv
// ---------------------------------------------------------------------------
// reg_bank_responder
//
// Register bank that answers the control unit's read/store handshake.
// A read_en pulse returns two registered operands one cycle later, marked by
// a one-cycle data_valid strobe. A write_en pulse stores write_data into the
// entry selected by in_destiny. When a read and a write hit the same index in
// the same cycle, the read returns the new value (write-first). This applies
// to each operand port on its own.
//
// Out-of-range indices can only occur when reg_depth is not a power of two.
// An out-of-range write is dropped. An out-of-range read operand returns 0.
// Either case raises err for one cycle.
//
// Optional build macro: REG_BANK_ZERO_REG_EN
//   When defined, entry 0 is hardwired to zero. Writes to index 0 are
//   silently discarded: they do not raise err and do not increment
//   write_count.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   read_en      read request strobe
//   src_a/src_b  operand indices
//   write_en     store request strobe
//   in_destiny   store index
//   write_data   store value
//   data_a/b     registered operands
//   data_valid   one-cycle pulse marking fresh operands
//   err          one-cycle pulse on any out-of-range access
//   write_count  committed-write counter, wraps modulo 256
// ---------------------------------------------------------------------------
module reg_bank_responder #(
    parameter int  reg_depth  = 8,
    parameter int  data_width = 4,
    localparam int addr_width = $clog2(reg_depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en,
    input  logic [addr_width-1:0] src_a,
    input  logic [addr_width-1:0] src_b,
    input  logic                  write_en,
    input  logic [addr_width-1:0] in_destiny,
    input  logic [data_width-1:0] write_data,
    output logic [data_width-1:0] data_a,
    output logic [data_width-1:0] data_b,
    output logic                  data_valid,
    output logic                  err,
    output logic [7:0]            write_count
);

    // One bit wider than the index ports, so the range check also works
    // when reg_depth is a power of two.
    localparam logic [addr_width:0] depth_ext = (addr_width + 1)'(reg_depth);

`ifdef REG_BANK_ZERO_REG_EN
    localparam bit zero_reg = 1'b1;
`else
    localparam bit zero_reg = 1'b0;
`endif

    logic [data_width-1:0] entry_reg [reg_depth];
    logic [data_width-1:0] data_a_reg, data_a_next;
    logic [data_width-1:0] data_b_reg, data_b_next;
    logic                  data_valid_reg;
    logic                  err_reg, err_next;
    logic [7:0]            write_count_reg;

    logic                  dest_in_range;
    logic                  write_commit;
    logic                  src_a_ok, src_b_ok;
    logic                  src_a_zero, src_b_zero;
    logic                  fwd_a, fwd_b;
    logic [reg_depth-1:0]  write_hit;

    assign dest_in_range = ({1'b0, in_destiny} < depth_ext);

    // A write to the hardwired zero entry is neither an error nor a commit.
    assign write_commit  = write_en && dest_in_range &&
                           !(zero_reg && (in_destiny == '0));

    assign src_a_ok   = ({1'b0, src_a} < depth_ext);
    assign src_b_ok   = ({1'b0, src_b} < depth_ext);
    assign src_a_zero = zero_reg && (src_a == '0);
    assign src_b_zero = zero_reg && (src_b == '0);

    // Forward only a write that actually commits. This keeps discarded
    // writes, such as those to the zero entry, off the read path.
    assign fwd_a = write_commit && (in_destiny == src_a);
    assign fwd_b = write_commit && (in_destiny == src_b);

    generate
        for (genvar gi = 0; gi < reg_depth; gi++) begin : g_write_hit
            assign write_hit[gi] = write_commit && (in_destiny == addr_width'(gi));
        end
    endgenerate

    always_comb begin
        data_a_next = data_a_reg;
        data_b_next = data_b_reg;
        if (read_en) begin
            if (!src_a_ok || src_a_zero) begin
                data_a_next = '0;
            end else if (fwd_a) begin
                data_a_next = write_data;
            end else begin
                data_a_next = entry_reg[src_a];
            end

            if (!src_b_ok || src_b_zero) begin
                data_b_next = '0;
            end else if (fwd_b) begin
                data_b_next = write_data;
            end else begin
                data_b_next = entry_reg[src_b];
            end
        end
    end

    // A write error and a read error in the same cycle merge into one pulse.
    always_comb begin
        err_next = (write_en && !dest_in_range) ||
                   (read_en && (!src_a_ok || !src_b_ok));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < reg_depth; i++) begin
                entry_reg[i] <= '0;
            end
            data_a_reg      <= '0;
            data_b_reg      <= '0;
            data_valid_reg  <= 1'b0;
            err_reg         <= 1'b0;
            write_count_reg <= '0;
        end else begin
            for (int i = 0; i < reg_depth; i++) begin
                if (write_hit[i]) begin
                    entry_reg[i] <= write_data;
                end
            end
            data_a_reg     <= data_a_next;
            data_b_reg     <= data_b_next;
            data_valid_reg <= read_en;
            err_reg        <= err_next;
            if (write_commit) begin
                write_count_reg <= write_count_reg + 8'd1;
            end
        end
    end

    assign data_a      = data_a_reg;
    assign data_b      = data_b_reg;
    assign data_valid  = data_valid_reg;
    assign err         = err_reg;
    assign write_count = write_count_reg;

endmodule
